// File: rtl/cricket_pkg.sv
// Shared types and default match parameters for the T20 innings sequencer.
package cricket_pkg;

  typedef enum logic [1:0] {
    ST_FIRST  = 2'd0,
    ST_BREAK  = 2'd1,
    ST_SECOND = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [2:0] OUT_WICKET = 3'd7;

  localparam int DEF_BALLS_PER_OVER = 6;
  localparam int DEF_MAX_OVERS      = 20;
  localparam int DEF_MAX_WICKETS    = 10;
  localparam int DEF_RUN_W          = 8;

  // Runs credited by one delivery; a wicket scores nothing.
  function automatic logic [2:0] runs_of(input logic [2:0] code);
    return (code == OUT_WICKET) ? 3'd0 : code;
  endfunction

endpackage

// File: rtl/innings_sequencer_over_counter.sv
// Ball-in-over / completed-overs counter pair, cleared between innings.
module over_counter
  import cricket_pkg::*;
#(
  parameter int BALLS_PER_OVER = DEF_BALLS_PER_OVER
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       i_clear,
  input  logic       i_ball,
  output logic [2:0] o_ball_in_over,
  output logic [4:0] o_overs,
  output logic       o_over_complete
);

  localparam logic [2:0] LAST_BALL = 3'(BALLS_PER_OVER - 1);

  logic [2:0] r_ball;
  logic [4:0] r_overs;

  // Combinational so the sequencer can judge innings end on the same edge.
  assign o_over_complete = i_ball && (r_ball == LAST_BALL);

  always_ff @(posedge clk) begin
    if (srst || i_clear) begin
      r_ball  <= '0;
      r_overs <= '0;
    end else if (i_ball) begin
      if (o_over_complete) begin
        r_ball  <= '0;
        r_overs <= r_overs + 5'd1;
      end else begin
        r_ball <= r_ball + 3'd1;
      end
    end
  end

  assign o_ball_in_over = r_ball;
  assign o_overs        = r_overs;

endmodule

// File: rtl/innings_sequencer.sv
// T20 innings sequencer: score accumulation, innings FSM, chase target and result.
module innings_sequencer
  import cricket_pkg::*;
#(
  parameter int BALLS_PER_OVER = DEF_BALLS_PER_OVER,
  parameter int MAX_OVERS      = DEF_MAX_OVERS,
  parameter int MAX_WICKETS    = DEF_MAX_WICKETS,
  parameter int RUN_W          = DEF_RUN_W
) (
  input  logic             clk_fpga,
  input  logic             reset,
  input  logic             play,
  input  logic [2:0]       outcome,
  input  logic             teamSwitch,
  output logic [RUN_W-1:0] binaryruns,
  output logic [3:0]       binarywickets,
  output logic [2:0]       ball_in_over,
  output logic [4:0]       overs,
  output logic             innings,
  output logic [RUN_W:0]   target,
  output logic             inningOver,
  output logic             gameOver,
  output logic             winner,
  output logic             tie
);

  state_e           r_state;
  logic [RUN_W-1:0] r_runs;
  logic [3:0]       r_wickets;
  logic             r_innings;
  logic [RUN_W:0]   r_target;
  logic             r_inning_over;
  logic             r_game_over;
  logic             r_winner;
  logic             r_tie;

  logic             w_ball;
  logic             w_clear;
  logic             w_over_complete;
  logic [RUN_W:0]   w_sum;
  logic [RUN_W-1:0] w_runs_next;
  logic [3:0]       w_wickets_next;
  logic [RUN_W:0]   w_runs_plus1;
  logic             w_innings_end;
  logic             w_chase_won;
  logic             w_tie;

  assign w_ball  = play && (r_state == ST_FIRST || r_state == ST_SECOND);
  assign w_clear = (r_state == ST_BREAK) && teamSwitch;

  over_counter #(
    .BALLS_PER_OVER (BALLS_PER_OVER)
  ) u_over_counter (
    .clk             (clk_fpga),
    .srst            (reset),
    .i_clear         (w_clear),
    .i_ball          (w_ball),
    .o_ball_in_over  (ball_in_over),
    .o_overs         (overs),
    .o_over_complete (w_over_complete)
  );

  // One spare bit catches overflow so the runs counter saturates instead of wrapping.
  assign w_sum          = {1'b0, r_runs} + (RUN_W+1)'(runs_of(outcome));
  assign w_runs_next    = w_sum[RUN_W] ? {RUN_W{1'b1}} : w_sum[RUN_W-1:0];
  assign w_wickets_next = r_wickets + {3'b000, (outcome == OUT_WICKET)};
  assign w_runs_plus1   = {1'b0, w_runs_next} + (RUN_W+1)'(1);

  assign w_innings_end = (w_wickets_next == 4'(MAX_WICKETS)) ||
                         (w_over_complete && (overs == 5'(MAX_OVERS - 1)));
  assign w_chase_won   = ({1'b0, w_runs_next} >= r_target);
  assign w_tie         = (w_runs_plus1 == r_target);

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      r_state       <= ST_FIRST;
      r_runs        <= '0;
      r_wickets     <= '0;
      r_innings     <= 1'b0;
      r_target      <= '0;
      r_inning_over <= 1'b0;
      r_game_over   <= 1'b0;
      r_winner      <= 1'b0;
      r_tie         <= 1'b0;
    end else begin
      unique case (r_state)
        ST_FIRST: begin
          if (w_ball) begin
            r_runs    <= w_runs_next;
            r_wickets <= w_wickets_next;
            if (w_innings_end) begin
              r_state       <= ST_BREAK;
              r_target      <= w_runs_plus1;
              r_inning_over <= 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (teamSwitch) begin
            r_state       <= ST_SECOND;
            r_runs        <= '0;
            r_wickets     <= '0;
            r_innings     <= 1'b1;
            r_inning_over <= 1'b0;
          end
        end
        ST_SECOND: begin
          if (w_ball) begin
            r_runs    <= w_runs_next;
            r_wickets <= w_wickets_next;
            // Reaching the target wins even on the last ball or last wicket.
            if (w_chase_won) begin
              r_state       <= ST_DONE;
              r_inning_over <= 1'b1;
              r_game_over   <= 1'b1;
              r_winner      <= 1'b1;
              r_tie         <= 1'b0;
            end else if (w_innings_end) begin
              r_state       <= ST_DONE;
              r_inning_over <= 1'b1;
              r_game_over   <= 1'b1;
              r_winner      <= 1'b0;
              r_tie         <= w_tie;
            end
          end
        end
        ST_DONE: begin
        end
        default: r_state <= ST_FIRST;
      endcase
    end
  end

  assign binaryruns    = r_runs;
  assign binarywickets = r_wickets;
  assign innings       = r_innings;
  assign target        = r_target;
  assign inningOver    = r_inning_over;
  assign gameOver      = r_game_over;
  assign winner        = r_winner;
  assign tie           = r_tie;

endmodule

// File: tb/tb_innings_sequencer.sv
// Self-checking bench for innings_sequencer: per-cycle match model plus directed scenarios.
module tb_innings_sequencer;

  localparam int RUN_W = 8;
  localparam int MAXR  = (1 << RUN_W) - 1;

  logic             clk_fpga = 1'b0;
  logic             reset = 1'b1;
  logic             play = 1'b0;
  logic [2:0]       outcome = 3'd0;
  logic             teamSwitch = 1'b0;
  logic [RUN_W-1:0] binaryruns;
  logic [3:0]       binarywickets;
  logic [2:0]       ball_in_over;
  logic [4:0]       overs;
  logic             innings;
  logic [RUN_W:0]   target;
  logic             inningOver;
  logic             gameOver;
  logic             winner;
  logic             tie;

  always #5 clk_fpga = ~clk_fpga;

  innings_sequencer #(
    .BALLS_PER_OVER (6),
    .MAX_OVERS      (20),
    .MAX_WICKETS    (10),
    .RUN_W          (RUN_W)
  ) dut (
    .clk_fpga      (clk_fpga),
    .reset         (reset),
    .play          (play),
    .outcome       (outcome),
    .teamSwitch    (teamSwitch),
    .binaryruns    (binaryruns),
    .binarywickets (binarywickets),
    .ball_in_over  (ball_in_over),
    .overs         (overs),
    .innings       (innings),
    .target        (target),
    .inningOver    (inningOver),
    .gameOver      (gameOver),
    .winner        (winner),
    .tie           (tie)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Match model: phase 0 = team 1 batting, 1 = break, 2 = team 2 batting, 3 = result
  int m_runs = 0, m_wk = 0, m_balls = 0, m_inn = 0, m_target = 0;
  int m_phase = 0, m_winner = 0, m_tie = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    bit ended;
    if (reset) begin
      m_runs = 0; m_wk = 0; m_balls = 0; m_inn = 0; m_target = 0;
      m_phase = 0; m_winner = 0; m_tie = 0;
      return;
    end
    case (m_phase)
      0, 2: begin
        if (play) begin
          if (outcome == 3'd7) m_wk++;
          else m_runs = (m_runs + int'(outcome) > MAXR) ? MAXR : m_runs + int'(outcome);
          m_balls++;
          ended = (m_wk == 10) || (m_balls == 120);
          if (m_phase == 0) begin
            if (ended) begin
              m_target = m_runs + 1;
              m_phase  = 1;
            end
          end else if (m_runs >= m_target) begin
            m_phase = 3; m_winner = 1; m_tie = 0;
          end else if (ended) begin
            m_phase = 3; m_winner = 0; m_tie = (m_runs == m_target - 1) ? 1 : 0;
          end
        end
      end
      1: begin
        if (teamSwitch) begin
          m_runs = 0; m_wk = 0; m_balls = 0; m_inn = 1; m_phase = 2;
        end
      end
      default: ;
    endcase
  endtask

  // Advance the model on each edge and compare all outputs shortly after it.
  always @(posedge clk_fpga) begin
    model_step();
    #1;
    chk("runs", int'(binaryruns), m_runs);
    chk("wickets", int'(binarywickets), m_wk);
    chk("ball_in_over", int'(ball_in_over), m_balls % 6);
    chk("overs", int'(overs), m_balls / 6);
    chk("innings", int'(innings), m_inn);
    chk("target", int'(target), m_target);
    chk("inningOver", int'(inningOver), (m_phase == 1 || m_phase == 3) ? 1 : 0);
    chk("gameOver", int'(gameOver), (m_phase == 3) ? 1 : 0);
    if (m_phase == 3) chk("tie", int'(tie), m_tie);
    if (m_phase == 3 && m_tie == 0) chk("winner", int'(winner), m_winner);
  end

  task automatic drive(input bit p, input int o, input bit ts, input bit r);
    @(negedge clk_fpga);
    play       = p;
    outcome    = 3'(o);
    teamSwitch = ts;
    reset      = r;
  endtask

  task automatic ball(input int o);
    drive(1'b1, o, 1'b0, 1'b0);
  endtask

  task automatic balls(input int n, input int o);
    for (int i = 0; i < n; i++) ball(o);
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic rst();
    drive(1'b0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic switch_sides();
    drive(1'b0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    rst();
    idle();
    chk("rst_runs", int'(binaryruns), 0);
    chk("rst_target", int'(target), 0);
    chk("rst_flags", int'({inningOver, gameOver, winner, tie, innings}), 0);

    // 120 singles, teamSwitch ignored while batting
    switch_sides();
    balls(119, 1);
    idle();
    chk("s1_not_over_119", int'(inningOver), 0);
    ball(1);
    idle();
    chk("s1_runs", int'(binaryruns), 120);
    chk("s1_overs", int'(overs), 20);
    chk("s1_bio", int'(ball_in_over), 0);
    chk("s1_inningOver", int'(inningOver), 1);
    chk("s1_target", int'(target), 121);
    ball(4);
    idle();
    chk("s1_extra_play", int'(binaryruns), 120);

    // 10 wickets in a row
    rst();
    balls(10, 7);
    idle();
    chk("s2_wickets", int'(binarywickets), 10);
    chk("s2_overs", int'(overs), 1);
    chk("s2_bio", int'(ball_in_over), 4);
    chk("s2_target", int'(target), 1);

    // Team 1 12 all out, team 2 chases with 6,6,4
    rst();
    balls(2, 6);
    balls(10, 7);
    idle();
    chk("s3_target", int'(target), 13);
    ball(6);
    idle();
    chk("s3_break_play", int'(binaryruns), 12);
    switch_sides();
    idle();
    chk("s3_innings", int'(innings), 1);
    chk("s3_cleared", int'(binaryruns) + int'(binarywickets) + int'(overs), 0);
    balls(2, 6);
    idle();
    chk("s3_not_done", int'(gameOver), 0);
    ball(4);
    idle();
    chk("s3_gameOver", int'(gameOver), 1);
    chk("s3_winner", int'(winner), 1);
    chk("s3_tie", int'(tie), 0);
    chk("s3_runs", int'(binaryruns), 16);
    drive(1'b1, 3, 1'b1, 1'b0);
    idle();
    chk("s3_done_hold", int'(binaryruns), 16);

    // Tie at 30, teamSwitch held high into the break
    rst();
    balls(5, 6);
    balls(9, 7);
    drive(1'b1, 7, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0);
    idle();
    chk("s4_innings", int'(innings), 1);
    balls(5, 6);
    balls(10, 7);
    idle();
    chk("s4_tie", int'(tie), 1);
    chk("s4_gameOver", int'(gameOver), 1);

    // Team 2 falls one short
    rst();
    balls(5, 6);
    balls(10, 7);
    switch_sides();
    balls(4, 6);
    ball(5);
    balls(10, 7);
    idle();
    chk("s4b_tie", int'(tie), 0);
    chk("s4b_winner", int'(winner), 0);
    chk("s4b_runs", int'(binaryruns), 29);

    // Chase completed on the 120th ball
    rst();
    balls(10, 7);
    switch_sides();
    balls(119, 0);
    idle();
    chk("s5_overs_119", int'(overs), 19);
    chk("s5_bio_119", int'(ball_in_over), 5);
    ball(1);
    idle();
    chk("s5_winner", int'(winner), 1);
    chk("s5_tie", int'(tie), 0);
    chk("s5_overs", int'(overs), 20);

    // Reset mid-second innings with a play pulse
    rst();
    balls(10, 7);
    switch_sides();
    ball(3);
    drive(1'b1, 6, 1'b0, 1'b1);
    idle();
    chk("s6_runs", int'(binaryruns), 0);
    chk("s6_innings", int'(innings), 0);
    chk("s6_target", int'(target), 0);
    ball(2);
    idle();
    chk("s6_first_again", int'(binaryruns), 2);

    // Saturation
    rst();
    balls(60, 6);
    idle();
    chk("s7_sat", int'(binaryruns), 255);
    chk("s7_overs", int'(overs), 10);
    balls(10, 7);
    idle();
    chk("s7_target", int'(target), 256);
    chk("s7_inningOver", int'(inningOver), 1);

    idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
